// File: rtl/rv_mem_pkg.sv
// ---------------------------------------------------------------------------
// rv_mem_pkg
// Shared definitions for the RV32IM data memory and its load-extension logic:
//   - funct3 encodings for byte/half/word loads and stores
//   - request FSM state type
//   - byte_en(): per-lane write enable for a store of a given size/offset
// ---------------------------------------------------------------------------
package rv_mem_pkg;

   localparam logic [2:0] F3_B  = 3'b000;  // LB / SB
   localparam logic [2:0] F3_H  = 3'b001;  // LH / SH
   localparam logic [2:0] F3_W  = 3'b010;  // LW / SW
   localparam logic [2:0] F3_BU = 3'b100;  // LBU
   localparam logic [2:0] F3_HU = 3'b101;  // LHU

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } mem_state_t;

   // Byte lanes touched by a store. Unsized/illegal encodings write nothing.
   function automatic logic [3:0] byte_en(input logic [2:0] funct3,
                                          input logic [1:0] addr_lo);
      case (funct3)
         F3_B:    byte_en = 4'b0001 << addr_lo;
         F3_H:    byte_en = 4'b0011 << addr_lo;
         F3_W:    byte_en = 4'b1111;
         default: byte_en = 4'b0000;
      endcase
   endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// ---------------------------------------------------------------------------
// lsu_load_extend
// Combinational load formatter: picks the addressed byte/halfword out of a
// 32-bit memory word and sign- or zero-extends it according to funct3.
// Also used by the cache refill path, so it carries no state.
//   word     in  32  raw memory word
//   addr_lo  in  2   byte offset within the word
//   funct3   in  3   load type (LB/LH/LW/LBU/LHU)
//   result   out 32  extended load value (0 for non-load encodings)
// ---------------------------------------------------------------------------
module lsu_load_extend
   import rv_mem_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  addr_lo,
   input  logic [2:0]  funct3,
   output logic [31:0] result
);

   logic [31:0] shifted;

   always_comb begin
      // Bring the addressed lane down to bit 0 before extending.
      shifted = word >> {addr_lo, 3'b000};
      case (funct3)
         F3_B:    result = {{24{shifted[7]}}, shifted[7:0]};
         F3_H:    result = {{16{shifted[15]}}, shifted[15:0]};
         F3_W:    result = shifted;
         F3_BU:   result = {24'h0, shifted[7:0]};
         F3_HU:   result = {16'h0, shifted[15:0]};
         default: result = 32'h0;
      endcase
   end

endmodule

// File: rtl/lsu_data_memory.sv
// ---------------------------------------------------------------------------
// lsu_data_memory
// Byte-addressed RV32IM data memory behind the MEM stage. One request at a
// time over valid/ready; the response appears LATENCY cycles after accept
// and is held until rsp_ready. Misaligned, out-of-range and illegal-funct3
// requests complete normally with rsp_err=1, rsp_rdata=0 and no write.
//   clk, rst              clock, asynchronous active-high reset
//   req_valid/req_ready   request handshake (ready only in IDLE)
//   req_we                1 = store, 0 = load
//   req_funct3            RISC-V load/store size encoding
//   req_addr              byte address
//   req_wdata             store data, LSB-aligned
//   rsp_valid/rsp_ready   response handshake
//   rsp_rdata             extended load data (0 for stores and errors)
//   rsp_err               request was rejected
// ---------------------------------------------------------------------------
module lsu_data_memory
   import rv_mem_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DEPTH   = 1024,
   parameter int LATENCY = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [2:0]        req_funct3,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_err
);

   localparam int IDX_W = $clog2(DEPTH);

   mem_state_t  state_q, state_d;
   logic [1:0]  cnt_q, cnt_d;
   logic        we_q, we_d;
   logic [2:0]  funct3_q, funct3_d;
   logic [1:0]  addr_lo_q, addr_lo_d;
   logic        err_q, err_d;
   logic        rsp_valid_q, rsp_valid_d;

   logic             accept;
   logic             misaligned, illegal_f3, out_of_range, req_err;
   logic [3:0]       wr_be;
   logic [31:0]      wr_data;
   logic [IDX_W-1:0] idx;
   logic [31:0]      rd_word;
   logic [31:0]      ext_data;

   // Gated by rst so nothing is accepted (or written) while reset is held.
   assign req_ready = (state_q == IDLE) && !rst;
   assign accept    = req_valid && req_ready;
   assign idx       = req_addr[IDX_W+1:2];

   // ---------------- request decode ----------------
   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no path
      // can leave it holding its old value and infer a latch.
      misaligned = 1'b0;
      illegal_f3 = 1'b0;
      wr_data    = req_wdata;
      case (req_funct3)
         F3_B, F3_BU: misaligned = 1'b0;
         F3_H, F3_HU: misaligned = req_addr[0];
         F3_W:        misaligned = |req_addr[1:0];
         default:     illegal_f3 = 1'b1;
      endcase
      // Unsigned variants only exist for loads.
      if (req_we && (req_funct3 == F3_BU || req_funct3 == F3_HU))
         illegal_f3 = 1'b1;
      // Compare the full word index so high addresses never alias into the array.
      out_of_range = (req_addr >> 2) >= ADDR_W'(DEPTH);
      req_err      = misaligned | illegal_f3 | out_of_range;
      // Replicate store data so whichever lane is enabled sees the right byte.
      case (req_funct3)
         F3_B:    wr_data = {4{req_wdata[7:0]}};
         F3_H:    wr_data = {2{req_wdata[15:0]}};
         default: wr_data = req_wdata;
      endcase
      wr_be = (accept && req_we && !req_err) ? byte_en(req_funct3, req_addr[1:0]) : 4'b0000;
   end

   // ---------------- storage: four byte lanes ----------------
   for (genvar lane = 0; lane < 4; lane++) begin : g_lane
      logic [7:0] mem [DEPTH];
      logic [7:0] rd_byte_q;
      // NOTE: the array and its read register have no reset; clearing a
      // RAM is not possible in one cycle and would block RAM inference.
      always_ff @(posedge clk) begin
         if (wr_be[lane]) mem[idx] <= wr_data[8*lane +: 8];
         if (accept)      rd_byte_q <= mem[idx];
      end
   end

   assign rd_word = {g_lane[3].rd_byte_q, g_lane[2].rd_byte_q,
                     g_lane[1].rd_byte_q, g_lane[0].rd_byte_q};

   lsu_load_extend u_extend (
      .word    (rd_word),
      .addr_lo (addr_lo_q),
      .funct3  (funct3_q),
      .result  (ext_data)
   );

   // ---------------- control FSM ----------------
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      we_d        = we_q;
      funct3_d    = funct3_q;
      addr_lo_d   = addr_lo_q;
      err_d       = err_q;
      rsp_valid_d = rsp_valid_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               we_d      = req_we;
               funct3_d  = req_funct3;
               addr_lo_d = req_addr[1:0];
               err_d     = req_err;
               if (LATENCY > 1) begin
                  state_d = WAIT;
                  // Counts down to 0 over LATENCY-1 cycles in WAIT.
                  cnt_d   = 2'(LATENCY - 2);
               end else begin
                  state_d     = RESP;
                  rsp_valid_d = 1'b1;
               end
            end
         end
         WAIT: begin
            if (cnt_q == 2'd0) begin
               state_d     = RESP;
               rsp_valid_d = 1'b1;
            end else begin
               cnt_d = cnt_q - 2'd1;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               state_d     = IDLE;
               rsp_valid_d = 1'b0;
            end
         end
         default: begin
            state_d     = IDLE;
            rsp_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= 2'd0;
         we_q        <= 1'b0;
         funct3_q    <= 3'd0;
         addr_lo_q   <= 2'd0;
         err_q       <= 1'b0;
         rsp_valid_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples the values
         // from before this edge, independent of statement order.
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         we_q        <= we_d;
         funct3_q    <= funct3_d;
         addr_lo_q   <= addr_lo_d;
         err_q       <= err_d;
         rsp_valid_q <= rsp_valid_d;
      end
   end

   // Outputs derive only from registered state, so they are stable while held.
   assign rsp_valid = rsp_valid_q;
   assign rsp_err   = rsp_valid_q && err_q;
   assign rsp_rdata = (rsp_valid_q && !we_q && !err_q) ? ext_data : 32'h0;

endmodule

// File: tb/tb_lsu_data_memory.sv
// ---------------------------------------------------------------------------
// tb_lsu_data_memory
// Drives two instances (LATENCY=1 and LATENCY=3) one after the other with
// directed and random requests. Expected data/err come from a byte-array
// model of the memory; key directed values are also checked against constants.
// ---------------------------------------------------------------------------
module tb_lsu_data_memory;

   localparam int DEPTH = 1024;
   localparam int NBYTE = DEPTH * 4;
   localparam int LAT [2] = '{1, 3};

   logic        clk = 1'b0;
   logic        rst        [2];
   logic        req_valid  [2];
   logic        req_ready  [2];
   logic        req_we     [2];
   logic [2:0]  req_funct3 [2];
   logic [31:0] req_addr   [2];
   logic [31:0] req_wdata  [2];
   logic        rsp_valid  [2];
   logic        rsp_ready  [2];
   logic [31:0] rsp_rdata  [2];
   logic        rsp_err    [2];

   int errors = 0;
   int checks = 0;

   logic [7:0] mdl [2][NBYTE];

   always #5 clk = ~clk;

   lsu_data_memory #(.ADDR_W(32), .DEPTH(DEPTH), .LATENCY(1)) u_dut1 (
      .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
      .req_we(req_we[0]), .req_funct3(req_funct3[0]), .req_addr(req_addr[0]),
      .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
      .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]));

   lsu_data_memory #(.ADDR_W(32), .DEPTH(DEPTH), .LATENCY(3)) u_dut3 (
      .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
      .req_we(req_we[1]), .req_funct3(req_funct3[1]), .req_addr(req_addr[1]),
      .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
      .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]));

   task automatic check(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s (lat=%0d): observed %h expected %h", tag, LAT[d], obs, exp);
      end
   endtask

   // Reference behaviour: size/sign from funct3, error rules, byte-wise memory.
   function automatic void model_op(input int d, input logic we, input logic [2:0] f3,
                                    input logic [31:0] addr, input logic [31:0] wd,
                                    output logic err, output logic [31:0] rd);
      int size;
      bit sgn;
      size = 0;
      sgn  = 0;
      rd   = 32'h0;
      case (f3)
         3'b000: begin size = 1; sgn = 1; end
         3'b001: begin size = 2; sgn = 1; end
         3'b010: begin size = 4; sgn = 0; end
         3'b100: if (!we) size = 1;
         3'b101: if (!we) size = 2;
         default: size = 0;
      endcase
      if (size == 0)                     err = 1'b1;
      else if ((addr % size) != 0)       err = 1'b1;
      else if ((addr / 4) >= DEPTH)      err = 1'b1;
      else                               err = 1'b0;
      if (!err) begin
         for (int i = 0; i < size; i++) begin
            if (we) mdl[d][int'(addr) + i] = wd[8*i +: 8];
            else    rd[8*i +: 8] = mdl[d][int'(addr) + i];
         end
         if (!we && sgn && size < 4 && rd[8*size-1])
            rd = rd | ~((32'd1 << (8*size)) - 32'd1);
      end
   endfunction

   // One complete transaction; response held for 'hold' cycles before rsp_ready.
   task automatic do_req(input int d, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd, input int hold,
                         output logic [31:0] got);
      logic        exp_err;
      logic [31:0] exp_rd;
      int          n;
      model_op(d, we, f3, addr, wd, exp_err, exp_rd);
      req_valid[d]  = 1'b1;
      req_we[d]     = we;
      req_funct3[d] = f3;
      req_addr[d]   = addr;
      req_wdata[d]  = wd;
      n = 0;
      while (!req_ready[d] && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      check("req_ready_before_accept", d, 32'(req_ready[d]), 32'd1);
      @(posedge clk); #1;                       // accept edge
      req_valid[d] = 1'b0;
      // n counts cycles after the accept cycle; rsp_valid must first show at n == LATENCY.
      n = 1;
      while (!rsp_valid[d] && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      check("rsp_latency", d, 32'(n), 32'(LAT[d]));
      check("rsp_err", d, 32'(rsp_err[d]), 32'(exp_err));
      check("rsp_rdata", d, rsp_rdata[d], exp_rd);
      got = rsp_rdata[d];
      if (hold > 0) begin
         // A junk store offered during the hold must be ignored.
         req_valid[d]  = 1'b1;
         req_we[d]     = 1'b1;
         req_funct3[d] = 3'b010;
         req_addr[d]   = 32'h0;
         req_wdata[d]  = 32'hBAD0BAD0;
         for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            check("hold_rsp_valid", d, 32'(rsp_valid[d]), 32'd1);
            check("hold_rsp_rdata", d, rsp_rdata[d], exp_rd);
            check("hold_rsp_err", d, 32'(rsp_err[d]), 32'(exp_err));
            check("hold_req_ready", d, 32'(req_ready[d]), 32'd0);
         end
      end
      rsp_ready[d] = 1'b1;
      @(posedge clk); #1;                       // response handshake edge
      rsp_ready[d] = 1'b0;
      req_valid[d] = 1'b0;
      check("post_hs_rsp_valid", d, 32'(rsp_valid[d]), 32'd0);
      check("post_hs_req_ready", d, 32'(req_ready[d]), 32'd1);
   endtask

   // Accept a word access, then reset while it is still in WAIT.
   task automatic reset_mid(input int d, input logic we, input logic [31:0] addr, input logic [31:0] wd);
      logic        e;
      logic [31:0] r;
      model_op(d, we, 3'b010, addr, wd, e, r);
      req_valid[d]  = 1'b1;
      req_we[d]     = we;
      req_funct3[d] = 3'b010;
      req_addr[d]   = addr;
      req_wdata[d]  = wd;
      check("rst_mid_ready", d, 32'(req_ready[d]), 32'd1);
      @(posedge clk); #1;
      req_valid[d] = 1'b0;
      rst[d] = 1'b1;
      #1;
      check("rst_mid_rsp_valid", d, 32'(rsp_valid[d]), 32'd0);
      check("rst_mid_req_ready", d, 32'(req_ready[d]), 32'd0);
      @(posedge clk); #1;
      rst[d] = 1'b0;
      #1;
      check("rst_rel_req_ready", d, 32'(req_ready[d]), 32'd1);
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         check("rst_no_stale_rsp", d, 32'(rsp_valid[d]), 32'd0);
      end
   endtask

   initial begin
      logic [31:0] got;
      logic [31:0] a;
      logic [2:0]  f3;
      for (int d = 0; d < 2; d++) begin
         rst[d] = 1'b1;  req_valid[d] = 1'b0; req_we[d] = 1'b0; req_funct3[d] = 3'd0;
         req_addr[d] = 32'h0; req_wdata[d] = 32'h0; rsp_ready[d] = 1'b0;
      end
      repeat (2) @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         check("reset_req_ready", d, 32'(req_ready[d]), 32'd0);
         check("reset_rsp_valid", d, 32'(rsp_valid[d]), 32'd0);
         check("reset_rsp_rdata", d, rsp_rdata[d], 32'h0);
         check("reset_rsp_err", d, 32'(rsp_err[d]), 32'd0);
      end
      rst[0] = 1'b0;
      rst[1] = 1'b0;
      @(posedge clk); #1;

      for (int d = 0; d < 2; d++) begin
         // Known contents for the low region and the top words of the array.
         for (int w = 0; w < 16; w++)
            do_req(d, 1'b1, 3'b010, 32'(w * 4), $urandom, 0, got);
         for (int w = DEPTH - 4; w < DEPTH; w++)
            do_req(d, 1'b1, 3'b010, 32'(w * 4), $urandom, 0, got);

         do_req(d, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 0, got);
         do_req(d, 1'b0, 3'b010, 32'h10, 32'h0, 0, got);
         check("lw_deadbeef", d, got, 32'hDEADBEEF);
         do_req(d, 1'b0, 3'b000, 32'h11, 32'h0, 0, got);
         check("lb_0x11", d, got, 32'hFFFFFFBE);
         do_req(d, 1'b0, 3'b100, 32'h13, 32'h0, 0, got);
         check("lbu_0x13", d, got, 32'h000000DE);
         do_req(d, 1'b0, 3'b001, 32'h12, 32'h0, 0, got);
         check("lh_0x12", d, got, 32'hFFFFDEAD);
         do_req(d, 1'b0, 3'b101, 32'h10, 32'h0, 0, got);
         check("lhu_0x10", d, got, 32'h0000BEEF);
         do_req(d, 1'b1, 3'b000, 32'h12, 32'hAAAAAA55, 0, got);
         do_req(d, 1'b0, 3'b010, 32'h10, 32'h0, 0, got);
         check("lw_after_sb", d, got, 32'hDE55BEEF);
         do_req(d, 1'b1, 3'b001, 32'h10, 32'hFFFF1234, 0, got);
         do_req(d, 1'b0, 3'b010, 32'h10, 32'h0, 0, got);
         check("lw_after_sh", d, got, 32'hDE551234);

         // Error cases: misaligned, out of range, illegal funct3; no writes happen.
         do_req(d, 1'b0, 3'b010, 32'h11, 32'h0, 0, got);
         do_req(d, 1'b1, 3'b001, 32'h13, 32'h0000EEEE, 0, got);
         do_req(d, 1'b1, 3'b100, 32'h10, 32'h77777777, 0, got);
         do_req(d, 1'b0, 3'b010, 32'(DEPTH * 4), 32'h0, 0, got);
         do_req(d, 1'b1, 3'b010, 32'(DEPTH * 4), 32'h99999999, 0, got);
         do_req(d, 1'b0, 3'b011, 32'h10, 32'h0, 0, got);
         do_req(d, 1'b0, 3'b010, 32'h10, 32'h0, 0, got);
         check("lw_unchanged_after_err", d, got, 32'hDE551234);
         do_req(d, 1'b0, 3'b010, 32'h0, 32'h0, 0, got);   // no alias from DEPTH*4

         // Held response with a junk request pending, then back-to-back traffic.
         do_req(d, 1'b0, 3'b010, 32'h10, 32'h0, 5, got);
         check("lw_after_hold", d, got, 32'hDE551234);
         do_req(d, 1'b0, 3'b010, 32'h0, 32'h0, 0, got);
         do_req(d, 1'b0, 3'b010, 32'((DEPTH - 1) * 4), 32'h0, 0, got);

         // Random traffic over the initialised regions plus stray addresses.
         for (int t = 0; t < 60; t++) begin
            case ($urandom_range(0, 9))
               0:       a = 32'(NBYTE - 16) + 32'($urandom_range(0, 15));
               1:       a = 32'(NBYTE) + 32'($urandom_range(0, 4096));
               default: a = 32'($urandom_range(0, 63));
            endcase
            f3 = 3'($urandom_range(0, 7));
            do_req(d, 1'($urandom_range(0, 1)), f3, a, $urandom, $urandom_range(0, 2), got);
         end
      end

      // Reset in the middle of a LATENCY=3 transaction: load, then store.
      reset_mid(1, 1'b0, 32'h10, 32'h0);
      reset_mid(1, 1'b1, 32'h20, 32'hCAFEF00D);
      do_req(1, 1'b0, 3'b010, 32'h20, 32'h0, 0, got);
      check("store_before_rst_kept", 1, got, 32'hCAFEF00D);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
